// File: rtl/lcisc_sub_pkg.sv
// Shared types for the multi-limb subtract unit.
// LCISC_SUB_SATURATE_EN turns mode 11 from reserved into SATSUB.
package lcisc_sub_pkg;

    typedef enum logic [1:0] {
        M_SUB    = 2'b00,
        M_RSUB   = 2'b01,
        M_CMP    = 2'b10,
`ifdef LCISC_SUB_SATURATE_EN
        M_SATSUB = 2'b11
`else
        M_RSVD   = 2'b11
`endif
    } sub_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } sub_state_e;

    // Width-independent part of the response; the unit wraps it with data/dest.
    typedef struct packed {
        logic write;
        logic borrow;
        logic zero;
        logic skipped;
        logic err;
    } sub_flags_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcisc_limb_sub.sv
// One WORD_W limb of the subtract chain: diff = a - b - bin, with borrow out.
module lcisc_limb_sub #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_bin,
    output logic [WORD_W-1:0] o_diff,
    output logic              o_bout
);

    logic [WORD_W:0] w_full;

    // The extra top bit goes to 1 exactly when the limb underflows.
    assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{WORD_W{1'b0}}, i_bin};
    assign o_diff = w_full[WORD_W-1:0];
    assign o_bout = w_full[WORD_W];

endmodule

// File: rtl/lcisc_sub_unit.sv
// Multi-limb subtract engine: one WORD_W limb per cycle, LSB first, borrow chained.
// Optional LCISC_SUB_SATURATE_EN: mode 11 becomes SATSUB instead of reserved/error.
module lcisc_sub_unit
    import lcisc_sub_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4,
    parameter int DEST_W    = 5,
    parameter int NUM_FLAGS = 8,
    localparam int W        = WORD_W * NUM_WORDS,
    localparam int SEL_W    = idx_w(NUM_FLAGS),
    localparam int CNT_W    = idx_w(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W-1:0]      req_op1,
    input  logic [W-1:0]      req_op2,
    input  logic [1:0]        req_mode,
    input  logic [DEST_W-1:0] req_dest,
    input  logic              req_cond_en,
    input  logic [SEL_W-1:0]  req_cond_sel,
    input  logic [NUM_FLAGS-1:0] flags_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [DEST_W-1:0] rsp_dest,
    output logic              rsp_write,
    output logic              rsp_borrow,
    output logic              rsp_zero,
    output logic              rsp_skipped,
    output logic              rsp_err
);

    typedef struct packed {
        logic [W-1:0]      data;
        logic [DEST_W-1:0] dest;
        sub_flags_t        flags;
    } sub_rsp_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

    sub_state_e       r_state;
    sub_mode_e        r_mode;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    sub_rsp_t         r_rsp;
    logic             r_rsp_valid;

    logic [WORD_W-1:0] w_diff;
    logic              w_bout;
    logic [W-1:0]      w_res_next;
    logic [W-1:0]      w_data_fin;
    logic              w_cond_fail;
    logic              w_rsvd;
    logic              w_swap;
    logic              w_clamp;

    lcisc_limb_sub #(.WORD_W(WORD_W)) u_limb (
        .i_a    (r_a[WORD_W-1:0]),
        .i_b    (r_b[WORD_W-1:0]),
        .i_bin  (r_borrow),
        .o_diff (w_diff),
        .o_bout (w_bout)
    );

    // Operands shift down one limb per cycle; results shift in from the top,
    // so after NUM_WORDS steps r_res holds the difference in natural order.
    assign w_res_next  = W'({w_diff, r_res} >> WORD_W);
    assign w_cond_fail = req_cond_en && !flags_in[req_cond_sel];
    assign w_swap      = (req_mode == M_RSUB);

`ifdef LCISC_SUB_SATURATE_EN
    assign w_rsvd  = 1'b0;
    assign w_clamp = (r_mode == M_SATSUB) && w_bout;
`else
    assign w_rsvd  = (req_mode == 2'b11);
    assign w_clamp = 1'b0;
`endif

    assign w_data_fin = w_clamp ? '0 : w_res_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= M_SUB;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_mode       <= sub_mode_e'(req_mode);
                        r_a          <= w_swap ? req_op2 : req_op1;
                        r_b          <= w_swap ? req_op1 : req_op2;
                        r_res        <= '0;
                        r_cnt        <= '0;
                        r_borrow     <= 1'b0;
                        r_rsp.dest   <= req_dest;
                        r_rsp.data   <= '0;
                        r_rsp.flags  <= '0;
                        if (w_cond_fail || w_rsvd) begin
                            // A false condition wins over a reserved mode: nothing ran.
                            r_state               <= S_DONE;
                            r_rsp_valid           <= 1'b1;
                            r_rsp.flags.skipped   <= w_cond_fail;
                            r_rsp.flags.err       <= !w_cond_fail;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_a      <= r_a >> WORD_W;
                    r_b      <= r_b >> WORD_W;
                    r_res    <= w_res_next;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state            <= S_DONE;
                        r_rsp_valid        <= 1'b1;
                        r_rsp.data         <= w_data_fin;
                        r_rsp.flags.write  <= (r_mode != M_CMP);
                        r_rsp.flags.borrow <= w_bout;
                        r_rsp.flags.zero   <= (w_data_fin == '0);
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp       <= '0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp.data;
    assign rsp_dest    = r_rsp.dest;
    assign rsp_write   = r_rsp.flags.write;
    assign rsp_borrow  = r_rsp.flags.borrow;
    assign rsp_zero    = r_rsp.flags.zero;
    assign rsp_skipped = r_rsp.flags.skipped;
    assign rsp_err     = r_rsp.flags.err;

endmodule
